// File: rtl/scaler_prescale_sequencer_if.sv
// rtl/scaler_prescale_sequencer_if.sv - WISHBONE master bus bundle for the prescale sequencer
// Purpose: groups the classic WISHBONE single-write master signals.
// Ports (master view):
//   wbm_cyc_o, wbm_stb_o, wbm_we_o : cycle / strobe / write enable
//   wbm_adr_o[15:0], wbm_dat_o[31:0], wbm_sel_o[3:0] : address, write data, byte selects
//   wbm_ack_i, wbm_err_i, wbm_rty_i : slave responses
interface scaler_prescale_sequencer_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [15:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i
  );
endinterface

// File: rtl/scaler_prescale_sequencer.sv
// rtl/scaler_prescale_sequencer.sv - walks a prescale table and writes each entry over WISHBONE
// Purpose: on start_i, writes NUM_SCALERS prescale words to PRESCALE_ADR, one per scaler,
//          with retry, timeout and error abort handling.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   tbl_wr_i/tbl_adr_i/tbl_dat_i : prescale table write port (usable at any time)
//   start_i                   : begin a sweep (accepted only when idle)
//   busy_o, done_o            : sweep in progress / one-cycle end-of-sweep pulse
//   err_o, err_idx_o          : sticky abort flag and the scaler index that aborted
//   wbm                       : WISHBONE master bus (interface, master modport)
module scaler_prescale_sequencer #(
  parameter int          NUM_SCALERS  = 32,
  parameter logic [15:0] PRESCALE_ADR = 16'h0004,
  parameter int          ACK_TIMEOUT  = 1023,
  parameter int          MAX_RETRY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tbl_wr_i,
  input  logic [5:0]  tbl_adr_i,
  input  logic [7:0]  tbl_dat_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [5:0]  err_idx_o,
  scaler_prescale_sequencer_if.master wbm
);

  localparam int         AW        = $clog2(NUM_SCALERS);
  localparam logic [6:0] N_L       = 7'(NUM_SCALERS);
  localparam logic [9:0] TO_LAST   = 10'(ACK_TIMEOUT - 1);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_GAP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  index_q, index_d;    // one bit wider than the table index so index==NUM_SCALERS is representable
  logic [7:0]  retry_q, retry_d;
  logic [9:0]  to_cnt_q, to_cnt_d;
  logic [7:0]  pre_q, pre_d;
  logic        err_q, err_d;
  logic [5:0]  err_idx_q, err_idx_d;

  // Table holds configuration across rst_i, so it has no reset term.
  logic [7:0]  tbl_q [NUM_SCALERS];

  always_ff @(posedge clk_i) begin
    if (tbl_wr_i && ({1'b0, tbl_adr_i} < N_L)) begin
      tbl_q[tbl_adr_i[AW-1:0]] <= tbl_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      retry_q   <= '0;
      to_cnt_q  <= '0;
      pre_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      retry_q   <= retry_d;
      to_cnt_q  <= to_cnt_d;
      pre_q     <= pre_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    retry_d   = retry_q;
    to_cnt_d  = to_cnt_q;
    pre_d     = pre_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          index_d = '0;
          retry_d = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        // Reads the registered table, so a same-cycle table write is not yet visible.
        pre_d    = tbl_q[index_q[AW-1:0]];
        to_cnt_d = '0;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        // err beats ack beats rty beats timeout.
        if (wbm.wbm_err_i) begin
          err_d     = 1'b1;
          err_idx_d = index_q[5:0];
          state_d   = S_DONE;
        end else if (wbm.wbm_ack_i) begin
          index_d = index_q + 7'd1;
          retry_d = '0;
          state_d = S_GAP;
        end else if (wbm.wbm_rty_i) begin
          if (retry_q == RETRY_MAX) begin
            err_d     = 1'b1;
            err_idx_d = index_q[5:0];
            state_d   = S_DONE;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = S_GAP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d     = 1'b1;
          err_idx_d = index_q[5:0];
          state_d   = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
      end
      S_GAP: begin
        state_d = (index_q < N_L) ? S_FETCH : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic wr_active;
  assign wr_active = (state_q == S_WRITE);

  // Bus outputs are forced to zero outside WRITE so idle/reset values are clean.
  assign wbm.wbm_cyc_o = wr_active;
  assign wbm.wbm_stb_o = wr_active;
  assign wbm.wbm_we_o  = wr_active;
  assign wbm.wbm_adr_o = wr_active ? PRESCALE_ADR : 16'h0000;
  assign wbm.wbm_sel_o = wr_active ? 4'b1001 : 4'b0000;
  assign wbm.wbm_dat_o = wr_active ? {1'b0, index_q, 16'h0000, pre_q} : 32'h0;

  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;
  assign err_idx_o = err_idx_q;

endmodule
